// File: rtl/event_arbiter.sv
`timescale 1ns/1ps
// Merges one-cycle event strobes from three sources through per-source holding registers and a round-robin arbiter into a FIFO.
// Latency 2 clocks pulse->outValid; a full FIFO stalls events in their holding registers, and a second strobe on an occupied holder is dropped and sets overflow.
module event_arbiter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          evFlag0,
  input  logic          evFlag1,
  input  logic          evFlag2,
  input  logic [7:0]    evCode0,
  input  logic [7:0]    evCode1,
  input  logic [7:0]    evCode2,
  output logic          outValid,
  output logic [7:0]    outCode,
  input  logic          outAck,
  output logic [CW-1:0] fifoCount,
  output logic          overflow,
  input  logic          ovfClr
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]    r_pend;
  logic [7:0]    r_code [3];
  logic [1:0]    r_last_gnt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_out_code;
  logic          r_ovf;

  logic [2:0]    w_flag;
  logic [7:0]    w_evcode [3];
  logic [2:0]    w_gnt;
  logic [1:0]    w_gnt_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [7:0]    w_push_dat;
  logic [7:0]    w_head_nxt;

  assign w_flag      = {evFlag2, evFlag1, evFlag0};
  assign w_evcode[0] = evCode0;
  assign w_evcode[1] = evCode1;
  assign w_evcode[2] = evCode2;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    logic [1:0] v_idx;
    w_gnt     = 3'b000;
    w_gnt_idx = 2'd0;
    w_push    = 1'b0;
    v_idx     = 2'd0;
    if (r_count < CW'(DEPTH)) begin
      for (int k = 1; k <= 3; k++) begin
        v_idx = 2'((int'(r_last_gnt) + k) % 3);
        if (!w_push && r_pend[v_idx]) begin
          w_push       = 1'b1;
          w_gnt_idx    = v_idx;
          w_gnt[v_idx] = 1'b1;
        end
      end
    end
  end

  assign w_push_dat = r_code[w_gnt_idx];
  assign w_pop      = outAck && (r_count != '0);
  assign w_drop     = |(w_flag & r_pend & ~w_gnt);

  // The head register must follow the entry that becomes oldest after this edge.
  always_comb begin
    w_head_nxt = r_out_code;
    if (w_pop) begin
      if (r_count > CW'(1))
        w_head_nxt = r_mem[r_rd_ptr + AW'(1)];
      else if (w_push)
        w_head_nxt = w_push_dat;
    end else if ((r_count == '0) && w_push) begin
      w_head_nxt = w_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 3'b000;
      r_last_gnt <= 2'd2;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_flag[i] && (!r_pend[i] || w_gnt[i])) begin
          r_pend[i] <= 1'b1;
          r_code[i] <= w_evcode[i];
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (w_push)
        r_last_gnt <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wr_ptr] <= w_push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_code <= 8'h00;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_out_code <= w_head_nxt;
      // A drop outranks a simultaneous clear.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovfClr)
        r_ovf <= 1'b0;
    end
  end

  assign outValid  = (r_count != '0);
  assign outCode   = r_out_code;
  assign fifoCount = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_event_arbiter.sv
`timescale 1ns/1ps
// Directed bench for event_arbiter: inputs change and outputs are checked on the falling edge.
module tb_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       evFlag0, evFlag1, evFlag2;
  logic [7:0] evCode0, evCode1, evCode2;
  logic       outValid;
  logic [7:0] outCode;
  logic       outAck;
  logic [3:0] fifoCount;
  logic       overflow;
  logic       ovfClr;

  int checks = 0;
  int errors = 0;

  always #500 clk = ~clk;

  event_arbiter #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .evFlag0(evFlag0), .evFlag1(evFlag1), .evFlag2(evFlag2),
    .evCode0(evCode0), .evCode1(evCode1), .evCode2(evCode2),
    .outValid(outValid), .outCode(outCode), .outAck(outAck),
    .fifoCount(fifoCount), .overflow(overflow), .ovfClr(ovfClr)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_all(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    evFlag0 = 1'b1; evFlag1 = 1'b1; evFlag2 = 1'b1;
    evCode0 = c0;   evCode1 = c1;   evCode2 = c2;
    tick();
    evFlag0 = 1'b0; evFlag1 = 1'b0; evFlag2 = 1'b0;
  endtask

  task automatic fair(input logic [7:0] base);
    pulse_all(base, base + 8'd1, base + 8'd2);
    tick(); tick(); tick();
    chk("fair_count", 32'(fifoCount), 32'd3);
    chk("fair_head0", 32'(outCode), 32'(base));
    outAck = 1'b1;
    tick(); chk("fair_head1", 32'(outCode), 32'(base + 8'd1));
    tick(); chk("fair_head2", 32'(outCode), 32'(base + 8'd2));
    tick(); chk("fair_empty", 32'(outValid), 32'd0);
    outAck = 1'b0;
  endtask

  initial begin
    rst = 1'b1; outAck = 1'b0; ovfClr = 1'b0;
    evFlag0 = 1'b0; evFlag1 = 1'b0; evFlag2 = 1'b0;
    evCode0 = 8'h00; evCode1 = 8'h00; evCode2 = 8'h00;
    @(negedge clk);
    tick(); tick();
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_code", 32'(outCode), 32'h00);
    chk("rst_count", 32'(fifoCount), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // single event, minimum latency, consumed immediately
    outAck = 1'b1;
    evFlag1 = 1'b1; evCode1 = 8'hA1;
    tick();
    evFlag1 = 1'b0; evCode1 = 8'h00;
    chk("single_e1_valid", 32'(outValid), 32'd0);
    tick();
    chk("single_e2_valid", 32'(outValid), 32'd1);
    chk("single_e2_code", 32'(outCode), 32'hA1);
    chk("single_e2_count", 32'(fifoCount), 32'd1);
    tick();
    chk("single_e3_valid", 32'(outValid), 32'd0);
    chk("single_e3_count", 32'(fifoCount), 32'd0);
    outAck = 1'b0;

    // fairness from reset, then wrap of the pointer back to source 0
    rst = 1'b1; tick(); rst = 1'b0;
    fair(8'h20);
    fair(8'h30);

    // backpressure: fill, hold one in pend, drop one
    for (int i = 0; i < 8; i++) begin
      evFlag0 = 1'b1; evCode0 = 8'h40 + 8'(i);
      tick();
      evFlag0 = 1'b0;
      tick(); tick(); tick();
    end
    chk("bp_full_count", 32'(fifoCount), 32'd8);
    chk("bp_full_head", 32'(outCode), 32'h40);
    chk("bp_full_ovf", 32'(overflow), 32'd0);
    evFlag0 = 1'b1; evCode0 = 8'h48;
    tick();
    evFlag0 = 1'b0;
    tick(); tick(); tick();
    chk("bp_ninth_count", 32'(fifoCount), 32'd8);
    chk("bp_ninth_ovf", 32'(overflow), 32'd0);
    evFlag0 = 1'b1; evCode0 = 8'h49;
    tick();
    evFlag0 = 1'b0;
    chk("bp_tenth_ovf", 32'(overflow), 32'd1);
    chk("bp_tenth_count", 32'(fifoCount), 32'd8);
    outAck = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("bp_drain_code", 32'(outCode), 32'h40 + 32'(k));
    end
    chk("bp_drain_count", 32'(fifoCount), 32'd1);
    tick();
    chk("bp_drained_valid", 32'(outValid), 32'd0);
    chk("bp_drained_count", 32'(fifoCount), 32'd0);
    outAck = 1'b0;
    ovfClr = 1'b1; tick(); ovfClr = 1'b0;
    chk("bp_ovf_cleared", 32'(overflow), 32'd0);

    // same-cycle recapture on source 2
    evFlag2 = 1'b1; evCode2 = 8'h05;
    tick();
    evCode2 = 8'h06;
    tick();
    evFlag2 = 1'b0;
    tick();
    chk("recap_count", 32'(fifoCount), 32'd2);
    chk("recap_head", 32'(outCode), 32'h05);
    chk("recap_ovf", 32'(overflow), 32'd0);
    outAck = 1'b1;
    tick(); chk("recap_second", 32'(outCode), 32'h06);
    tick(); chk("recap_empty", 32'(fifoCount), 32'd0);
    outAck = 1'b0;

    // simultaneous push and pop at count 3, then ack while empty
    pulse_all(8'h50, 8'h51, 8'h52);
    tick(); tick(); tick();
    chk("pp_pre_count", 32'(fifoCount), 32'd3);
    evFlag1 = 1'b1; evCode1 = 8'h53;
    tick();
    evFlag1 = 1'b0;
    outAck = 1'b1;
    tick();
    chk("pp_count", 32'(fifoCount), 32'd3);
    chk("pp_head", 32'(outCode), 32'h51);
    tick(); chk("pp_drain52", 32'(outCode), 32'h52);
    tick(); chk("pp_drain53", 32'(outCode), 32'h53);
    tick(); chk("pp_drained", 32'(fifoCount), 32'd0);
    tick();
    chk("ack_empty_count", 32'(fifoCount), 32'd0);
    chk("ack_empty_valid", 32'(outValid), 32'd0);
    outAck = 1'b0;

    // reset mid-stream with five queued and two pending
    pulse_all(8'h60, 8'h61, 8'h62);
    tick(); tick(); tick();
    evFlag0 = 1'b1; evCode0 = 8'h63;
    tick();
    evFlag0 = 1'b0;
    tick();
    pulse_all(8'h64, 8'h65, 8'h66);
    evFlag0 = 1'b1; evCode0 = 8'h67;
    tick();
    evFlag0 = 1'b0;
    chk("mid_count", 32'(fifoCount), 32'd5);
    chk("mid_ovf", 32'(overflow), 32'd1);
    rst = 1'b1; evFlag1 = 1'b1; evCode1 = 8'hEE;
    tick();
    rst = 1'b0; evFlag1 = 1'b0;
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    chk("mid_rst_count", 32'(fifoCount), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_code", 32'(outCode), 32'h00);
    tick(); tick();
    chk("mid_idle_count", 32'(fifoCount), 32'd0);
    evFlag1 = 1'b1; evCode1 = 8'h7A;
    tick();
    evFlag1 = 1'b0;
    chk("post_rst_e1", 32'(outValid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(outValid), 32'd1);
    chk("post_rst_code", 32'(outCode), 32'h7A);

    // drop in the same cycle as ovfClr keeps the flag set
    evFlag0 = 1'b1; evCode0 = 8'h80;
    evFlag2 = 1'b1; evCode2 = 8'h82;
    tick();
    evFlag2 = 1'b0;
    evCode0 = 8'h81; ovfClr = 1'b1;
    tick();
    evFlag0 = 1'b0; ovfClr = 1'b0;
    chk("drop_beats_clr", 32'(overflow), 32'd1);
    tick();
    chk("drop_count", 32'(fifoCount), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
